// File: rtl/mac_acc_mem.sv
// Operand/result store for the MAC datapath: A (M x K), B (K x N), C (M x N).
// Registered reads with one-cycle valid flags, in-place accumulate on C,
// and a row-sweep engine that zeroes C between jobs.
module mac_acc_mem #(
  parameter int M = 4,
  parameter int K = 4,
  parameter int N = 4,
  parameter int DATA_WIDTH_INIT_MATRIX = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K),
  localparam int MW = (M > 1) ? $clog2(M) : 1,
  localparam int KW = (K > 1) ? $clog2(K) : 1,
  localparam int NW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_a,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_b,
  input  logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
  input  logic [MW-1:0]                       row_addr_a,
  input  logic [KW-1:0]                       col_addr_a,
  input  logic [KW-1:0]                       row_addr_b,
  input  logic [NW-1:0]                       col_addr_b,
  input  logic [MW-1:0]                       row_addr_c,
  input  logic [NW-1:0]                       col_addr_c,
  input  logic                                matrix_a_we,
  input  logic                                matrix_b_we,
  input  logic                                matrix_c_we,
  input  logic                                matrix_c_acc,
  input  logic                                matrix_a_re,
  input  logic                                matrix_b_re,
  input  logic                                matrix_c_re,
  input  logic                                clear_start,
  output logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
  output logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_out_c,
  output logic                                rvalid_a,
  output logic                                rvalid_b,
  output logic                                rvalid_c,
  output logic                                c_busy,
  output logic                                clear_done,
  output logic                                c_drop_err
);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DATA_WIDTH_INIT_MATRIX-1:0]   memA_q [M][K];
  logic [DATA_WIDTH_INIT_MATRIX-1:0]   memB_q [K][N];
  logic [DATA_WIDTH_RESULT_MATRIX-1:0] memC_q [M][N];

  logic [DATA_WIDTH_INIT_MATRIX-1:0]   dataOutA_q, dataOutB_q;
  logic [DATA_WIDTH_RESULT_MATRIX-1:0] dataOutC_q;
  logic                                rvalidA_q, rvalidB_q, rvalidC_q;
  logic                                dropErr_q;

  state_t        state_q, state_d;
  logic [MW-1:0] rowPtr_q, rowPtr_d;
  logic          clearDone_q, clearDone_d;

  logic aInRange, bInRange, cInRange, cBusy, lastRow;

  // Addresses beyond the matrix size only exist for non-power-of-2 dimensions
  assign aInRange = (32'(row_addr_a) < M) && (32'(col_addr_a) < K);
  assign bInRange = (32'(row_addr_b) < K) && (32'(col_addr_b) < N);
  assign cInRange = (32'(row_addr_c) < M) && (32'(col_addr_c) < N);
  assign cBusy    = (state_q == CLEAR);
  assign lastRow  = (32'(rowPtr_q) == M - 1);

  // A port: write, and read-first registered read with one-cycle valid
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < K; c++)
          memA_q[r][c] <= '0;
      dataOutA_q <= '0;
      rvalidA_q  <= 1'b0;
    end else begin
      if (matrix_a_we && aInRange)
        memA_q[row_addr_a][col_addr_a] <= data_in_a;
      rvalidA_q <= matrix_a_re;
      if (matrix_a_re)
        dataOutA_q <= aInRange ? memA_q[row_addr_a][col_addr_a] : '0;
    end
  end

  // B port: identical behaviour to A over the K x N array
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < N; c++)
          memB_q[r][c] <= '0;
      dataOutB_q <= '0;
      rvalidB_q  <= 1'b0;
    end else begin
      if (matrix_b_we && bInRange)
        memB_q[row_addr_b][col_addr_b] <= data_in_b;
      rvalidB_q <= matrix_b_re;
      if (matrix_b_re)
        dataOutB_q <= bInRange ? memB_q[row_addr_b][col_addr_b] : '0;
    end
  end

  // C port: sweep clears one row per cycle and drops host commands; otherwise write beats accumulate
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          memC_q[r][c] <= '0;
      dataOutC_q <= '0;
      rvalidC_q  <= 1'b0;
      dropErr_q  <= 1'b0;
    end else begin
      rvalidC_q <= 1'b0;
      if (cBusy) begin
        for (int c = 0; c < N; c++)
          memC_q[rowPtr_q][c] <= '0;
        if (matrix_c_we || matrix_c_acc || matrix_c_re)
          dropErr_q <= 1'b1;
      end else begin
        if (cInRange) begin
          if (matrix_c_we)
            memC_q[row_addr_c][col_addr_c] <= data_in_c;
          else if (matrix_c_acc)
            memC_q[row_addr_c][col_addr_c] <= memC_q[row_addr_c][col_addr_c] + data_in_c;
        end
        if (matrix_c_re) begin
          rvalidC_q  <= 1'b1;
          dataOutC_q <= cInRange ? memC_q[row_addr_c][col_addr_c] : '0;
        end
      end
    end
  end

  // Clear engine state register; reset aborts a sweep without a done pulse
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rowPtr_q    <= '0;
      clearDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rowPtr_q    <= rowPtr_d;
      clearDone_q <= clearDone_d;
    end
  end

  // Clear engine next state: walk rows 0..M-1, flag completion after the last one
  always_comb begin
    state_d     = state_q;
    rowPtr_d    = rowPtr_q;
    clearDone_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d  = CLEAR;
          rowPtr_d = '0;
        end
      end
      CLEAR: begin
        if (lastRow) begin
          state_d     = IDLE;
          rowPtr_d    = '0;
          clearDone_d = 1'b1;
        end else begin
          rowPtr_d = rowPtr_q + MW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out_a = dataOutA_q;
  assign data_out_b = dataOutB_q;
  assign data_out_c = dataOutC_q;
  assign rvalid_a   = rvalidA_q;
  assign rvalid_b   = rvalidB_q;
  assign rvalid_c   = rvalidC_q;
  assign c_busy     = cBusy;
  assign clear_done = clearDone_q;
  assign c_drop_err = dropErr_q;

endmodule
